burst_ram_arbiter: RTL and testbench

//  Shares one BurstRAM between two burst masters: port 0 (instruction cache, read only) and port 1 (data cache, read/write).

---
 rtl/burst_ram_pkg.sv | 22 ++
 rtl/burst_beat_counter.sv | 38 +++
 rtl/burst_ram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_ram_pkg.sv
// Shared definitions for the BurstRAM arbiter.
// Contents:
//   state_t  - arbiter FSM states (idle, collecting read beats, sending write beats)
//   port_t   - master port identifiers
//   CMD_READ / CMD_WRITE - br_cmd / m1_cmd encodings
package burst_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_beat_counter.sv
// Beat counter for one burst.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clear       - return the count to 0 (wins over advance)
//   advance     - step the count by one beat
//   last        - count is on the final beat (COUNT-1)
//   penult      - count is on the beat before the final one (COUNT-2)
// The count wraps to 0 naturally after COUNT-1 because COUNT is a power of 2.
module burst_beat_counter #(
  parameter int COUNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic advance,
  output logic last,
  output logic penult
);

  localparam int CW = $clog2(COUNT);

  logic [CW-1:0] count;

  // Beat count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance) begin
      count <= count + 1'b1;
    end
  end

  assign last   = (count == CW'(COUNT - 1));
  assign penult = (count == CW'(COUNT - 2));

endmodule

// File: rtl/burst_ram_arbiter.sv
// Two-master BurstRAM arbiter: port 0 (instruction cache, read only) and
// port 1 (data cache, read/write) share one BurstRAM, one whole burst at a time.
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   m0_cmd_en, m0_addr               - port 0 read request (held until m0_grant)
//   m0_grant, m0_rd_data(_valid), m0_busy - port 0 responses
//   m1_cmd, m1_cmd_en, m1_addr, m1_wr_data, m1_data_mask - port 1 request / write beats
//   m1_grant, m1_rd_data(_valid), m1_busy - port 1 responses
//   br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask - command side to BurstRAM
//   br_rd_data, br_rd_data_valid, br_busy - returns from BurstRAM
// Configuration macro: BURST_RAM_ARBITER_ROUND_ROBIN_EN
//   defined   - simultaneous requests go to the port not granted last (m1 first after reset)
//   undefined - fixed priority, m1 over m0
module burst_ram_arbiter
  import burst_ram_pkg::*;
#(
  parameter int RAM_DEPTH_BITWIDTH      = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int RAM_BURST_DATA_COUNT    = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   m0_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]          m0_addr,
  output logic                                   m0_grant,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]     m0_rd_data,
  output logic                                   m0_rd_data_valid,
  output logic                                   m0_busy,
  input  logic                                   m1_cmd,
  input  logic                                   m1_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]          m1_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     m1_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   m1_data_mask,
  output logic                                   m1_grant,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]     m1_rd_data,
  output logic                                   m1_rd_data_valid,
  output logic                                   m1_busy,
  output logic                                   br_cmd,
  output logic                                   br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]          br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_rd_data,
  input  logic                                   br_rd_data_valid,
  input  logic                                   br_busy
);

  state_t state, state_next;
  port_t  owner;
  logic   grant_now;
  logic   pick_m1;
  logic   cnt_clear;
  logic   cnt_advance;
  logic   beat_last;
  logic   beat_penult;

`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
  port_t  last_winner;
`endif

  burst_beat_counter #(
    .COUNT (RAM_BURST_DATA_COUNT)
  ) u_beat_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .last    (beat_last),
    .penult  (beat_penult)
  );

  // Read data goes to both ports unconditionally; only the valid is steered.
  assign m0_rd_data = br_rd_data;
  assign m1_rd_data = br_rd_data;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Winner selection, next state, beat counting, read-valid steering and busy flags
  always_comb begin
    state_next       = state;
    grant_now        = 1'b0;
    pick_m1          = m1_cmd_en;
    cnt_clear        = 1'b0;
    cnt_advance      = 1'b0;
    m0_rd_data_valid = 1'b0;
    m1_rd_data_valid = 1'b0;

`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
    if (m0_cmd_en && m1_cmd_en) begin
      pick_m1 = (last_winner == PORT0);
    end
`endif

    case (state)
      ST_IDLE: begin
        if (!br_busy && (m0_cmd_en || m1_cmd_en)) begin
          grant_now  = 1'b1;
          cnt_clear  = 1'b1;
          state_next = (pick_m1 && (m1_cmd == CMD_WRITE)) ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if (br_rd_data_valid) begin
          if (owner == PORT0) begin
            m0_rd_data_valid = 1'b1;
          end else begin
            m1_rd_data_valid = 1'b1;
          end
          cnt_advance = 1'b1;
          if (beat_last) begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_WRITE: begin
        // Beat 0 went out with the grant, so the burst ends once beat
        // COUNT-1 is registered, i.e. while the count sits on COUNT-2.
        if (beat_penult) begin
          cnt_clear  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_advance = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    m0_busy = (state != ST_IDLE) || br_busy || (grant_now && pick_m1);
    m1_busy = (state != ST_IDLE) || br_busy || (grant_now && !pick_m1);
  end

  // Command-side registers, grant pulses and burst owner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cmd       <= CMD_READ;
      br_cmd_en    <= 1'b0;
      br_addr      <= '0;
      br_wr_data   <= '0;
      br_data_mask <= '0;
      m0_grant     <= 1'b0;
      m1_grant     <= 1'b0;
      owner        <= PORT0;
`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
      last_winner  <= PORT0;
`endif
    end else begin
      br_cmd_en <= 1'b0;
      m0_grant  <= 1'b0;
      m1_grant  <= 1'b0;
      if (grant_now) begin
        br_cmd_en <= 1'b1;
        if (pick_m1) begin
          br_cmd       <= m1_cmd;
          br_addr      <= m1_addr;
          br_wr_data   <= m1_wr_data;
          br_data_mask <= m1_data_mask;
          m1_grant     <= 1'b1;
          owner        <= PORT1;
        end else begin
          br_cmd       <= CMD_READ;
          br_addr      <= m0_addr;
          br_wr_data   <= '0;
          br_data_mask <= '0;
          m0_grant     <= 1'b1;
          owner        <= PORT0;
        end
`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
        last_winner <= pick_m1 ? PORT1 : PORT0;
`endif
      end else if (state == ST_WRITE) begin
        br_wr_data   <= m1_wr_data;
        br_data_mask <= m1_data_mask;
      end
    end
  end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Testbench for burst_ram_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_burst_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int NB = 4;

  logic          clk;
  logic          rst_n;
  logic          m0_cmd_en;
  logic [AW-1:0] m0_addr;
  logic          m0_grant;
  logic [DW-1:0] m0_rd_data;
  logic          m0_rd_data_valid;
  logic          m0_busy;
  logic          m1_cmd;
  logic          m1_cmd_en;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wr_data;
  logic [MW-1:0] m1_data_mask;
  logic          m1_grant;
  logic [DW-1:0] m1_rd_data;
  logic          m1_rd_data_valid;
  logic          m1_busy;
  logic          br_cmd;
  logic          br_cmd_en;
  logic [AW-1:0] br_addr;
  logic [DW-1:0] br_wr_data;
  logic [MW-1:0] br_data_mask;
  logic [DW-1:0] br_rd_data;
  logic          br_rd_data_valid;
  logic          br_busy;

  int n_vec = 0;
  int n_err = 0;

  burst_ram_arbiter #(
    .RAM_DEPTH_BITWIDTH      (AW),
    .RAM_BURST_DATA_BITWIDTH (DW),
    .RAM_BURST_DATA_COUNT    (NB)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .m0_cmd_en        (m0_cmd_en),
    .m0_addr          (m0_addr),
    .m0_grant         (m0_grant),
    .m0_rd_data       (m0_rd_data),
    .m0_rd_data_valid (m0_rd_data_valid),
    .m0_busy          (m0_busy),
    .m1_cmd           (m1_cmd),
    .m1_cmd_en        (m1_cmd_en),
    .m1_addr          (m1_addr),
    .m1_wr_data       (m1_wr_data),
    .m1_data_mask     (m1_data_mask),
    .m1_grant         (m1_grant),
    .m1_rd_data       (m1_rd_data),
    .m1_rd_data_valid (m1_rd_data_valid),
    .m1_busy          (m1_busy),
    .br_cmd           (br_cmd),
    .br_cmd_en        (br_cmd_en),
    .br_addr          (br_addr),
    .br_wr_data       (br_wr_data),
    .br_data_mask     (br_data_mask),
    .br_rd_data       (br_rd_data),
    .br_rd_data_valid (br_rd_data_valid),
    .br_busy          (br_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One directed cycle: inputs driven for the cycle, outputs expected in that same cycle.
  typedef struct packed {
    logic          m0_en;
    logic [AW-1:0] m0_a;
    logic          m1_en;
    logic          m1_c;
    logic [AW-1:0] m1_a;
    logic [DW-1:0] m1_wd;
    logic [MW-1:0] m1_m;
    logic          busy;
    logic          vld;
    logic [DW-1:0] rd;
    logic          e_g0;
    logic          e_g1;
    logic          e_v0;
    logic          e_v1;
    logic          e_b0;
    logic          e_b1;
    logic          e_cen;
    logic [AW-1:0] e_addr;
    logic          e_cmd;
    logic          chk_wd;
    logic [DW-1:0] e_wd;
    logic [MW-1:0] e_mask;
  } vec_t;

  vec_t tbl[$];

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearInputs();
    m0_cmd_en        = 1'b0;
    m0_addr          = '0;
    m1_cmd           = 1'b0;
    m1_cmd_en        = 1'b0;
    m1_addr          = '0;
    m1_wr_data       = '0;
    m1_data_mask     = '0;
    br_busy          = 1'b0;
    br_rd_data_valid = 1'b0;
    br_rd_data       = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    m0_cmd_en        = v.m0_en;
    m0_addr          = v.m0_a;
    m1_cmd_en        = v.m1_en;
    m1_cmd           = v.m1_c;
    m1_addr          = v.m1_a;
    m1_wr_data       = v.m1_wd;
    m1_data_mask     = v.m1_m;
    br_busy          = v.busy;
    br_rd_data_valid = v.vld;
    br_rd_data       = v.rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic doReset();
    tick();
    rst_n = 1'b0;
    clearInputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Transaction-level reference: a burst in flight is just "work left"
  // (beats still to arrive for a read, beat cycles still to send for a write).
  int            mdl_left;
  logic          mdl_owner1;
  logic          mdl_write;
  logic          mdl_last1;
  logic          mdl_chk_w;
  logic          mdl_g0, mdl_g1, mdl_cen, mdl_cmd;
  logic [AW-1:0] mdl_addr;
  logic [DW-1:0] mdl_wd;
  logic [MW-1:0] mdl_mask;

  task automatic modelReset();
    mdl_left   = 0;
    mdl_owner1 = 1'b0;
    mdl_write  = 1'b0;
    mdl_last1  = 1'b0;
    mdl_chk_w  = 1'b0;
    mdl_g0     = 1'b0;
    mdl_g1     = 1'b0;
    mdl_cen    = 1'b0;
    mdl_cmd    = 1'b0;
    mdl_addr   = '0;
    mdl_wd     = '0;
    mdl_mask   = '0;
  endtask

  initial begin
    logic free, pick1, win;
    int   order[$];

    rst_n = 1'b0;
    clearInputs();
    doReset();

    // Reset state
    sample();
    checkOutput("rst_m0_grant", m0_grant, 0);
    checkOutput("rst_m1_grant", m1_grant, 0);
    checkOutput("rst_br_cmd_en", br_cmd_en, 0);
    checkOutput("rst_br_addr", br_addr, 0);
    checkOutput("rst_br_wr_data", br_wr_data, 0);
    checkOutput("rst_m0_busy", m0_busy, 0);
    checkOutput("rst_m1_busy", m1_busy, 0);

    // m0 read addr 3 / m1 write addr 5 / br_busy hold-off
    //                 m0e a  m1e c a  wd      mask   bsy vld rd       g0 g1 v0 v1 b0 b1 cen addr cmd chk wd      mask
    tbl.push_back(vec_t'{1, 3, 0, 0, 0, 64'h0,  8'h00, 0, 0, 64'h0,  0, 0, 0, 0, 0, 1, 0,  0,   0,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 64'h0,  8'h00, 0, 0, 64'h0,  1, 0, 0, 0, 1, 1, 1,  3,   0,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 64'h0,  8'h00, 0, 1, 64'hA1, 0, 0, 1, 0, 1, 1, 0,  3,   0,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 64'h0,  8'h00, 0, 1, 64'hA2, 0, 0, 1, 0, 1, 1, 0,  3,   0,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 64'h0,  8'h00, 0, 1, 64'hA3, 0, 0, 1, 0, 1, 1, 0,  3,   0,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 64'h0,  8'h00, 0, 1, 64'hA4, 0, 0, 1, 0, 1, 1, 0,  3,   0,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 64'h0,  8'h00, 0, 1, 64'hA5, 0, 0, 0, 0, 0, 0, 0,  3,   0,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{0, 0, 1, 1, 5, 64'h11, 8'hFF, 0, 0, 64'h0,  0, 0, 0, 0, 1, 0, 0,  3,   0,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{0, 0, 0, 1, 5, 64'h22, 8'hFF, 0, 0, 64'h0,  0, 1, 0, 0, 1, 1, 1,  5,   1,  1,  64'h11, 8'hFF});
    tbl.push_back(vec_t'{0, 0, 0, 1, 5, 64'h33, 8'hFF, 0, 0, 64'h0,  0, 0, 0, 0, 1, 1, 0,  5,   1,  1,  64'h22, 8'hFF});
    tbl.push_back(vec_t'{0, 0, 0, 1, 5, 64'h44, 8'hFF, 0, 0, 64'h0,  0, 0, 0, 0, 1, 1, 0,  5,   1,  1,  64'h33, 8'hFF});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 64'h0,  8'h00, 0, 0, 64'h0,  0, 0, 0, 0, 0, 0, 0,  5,   1,  1,  64'h44, 8'hFF});
    tbl.push_back(vec_t'{1, 7, 0, 0, 0, 64'h0,  8'h00, 1, 0, 64'h0,  0, 0, 0, 0, 1, 1, 0,  5,   1,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{1, 7, 0, 0, 0, 64'h0,  8'h00, 1, 0, 64'h0,  0, 0, 0, 0, 1, 1, 0,  5,   1,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{1, 7, 0, 0, 0, 64'h0,  8'h00, 0, 0, 64'h0,  0, 0, 0, 0, 0, 1, 0,  5,   1,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 64'h0,  8'h00, 0, 0, 64'h0,  1, 0, 0, 0, 1, 1, 1,  7,   0,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 64'h0,  8'h00, 0, 1, 64'hB1, 0, 0, 1, 0, 1, 1, 0,  7,   0,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 64'h0,  8'h00, 0, 1, 64'hB2, 0, 0, 1, 0, 1, 1, 0,  7,   0,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 64'h0,  8'h00, 0, 1, 64'hB3, 0, 0, 1, 0, 1, 1, 0,  7,   0,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 64'h0,  8'h00, 0, 1, 64'hB4, 0, 0, 1, 0, 1, 1, 0,  7,   0,  0,  64'h0,  8'h00});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 64'h0,  8'h00, 0, 0, 64'h0,  0, 0, 0, 0, 0, 0, 0,  7,   0,  0,  64'h0,  8'h00});

    foreach (tbl[i]) begin
      tick();
      applyStimulus(tbl[i]);
      sample();
      checkOutput($sformatf("tbl%0d_m0_grant", i), m0_grant, tbl[i].e_g0);
      checkOutput($sformatf("tbl%0d_m1_grant", i), m1_grant, tbl[i].e_g1);
      checkOutput($sformatf("tbl%0d_m0_valid", i), m0_rd_data_valid, tbl[i].e_v0);
      checkOutput($sformatf("tbl%0d_m1_valid", i), m1_rd_data_valid, tbl[i].e_v1);
      checkOutput($sformatf("tbl%0d_m0_busy", i), m0_busy, tbl[i].e_b0);
      checkOutput($sformatf("tbl%0d_m1_busy", i), m1_busy, tbl[i].e_b1);
      checkOutput($sformatf("tbl%0d_br_cmd_en", i), br_cmd_en, tbl[i].e_cen);
      checkOutput($sformatf("tbl%0d_br_addr", i), br_addr, tbl[i].e_addr);
      checkOutput($sformatf("tbl%0d_br_cmd", i), br_cmd, tbl[i].e_cmd);
      if (tbl[i].vld) begin
        checkOutput($sformatf("tbl%0d_m0_rd_data", i), m0_rd_data, tbl[i].rd);
      end
      if (tbl[i].chk_wd) begin
        checkOutput($sformatf("tbl%0d_br_wr_data", i), br_wr_data, tbl[i].e_wd);
        checkOutput($sformatf("tbl%0d_br_data_mask", i), br_data_mask, tbl[i].e_mask);
      end
    end

    // Simultaneous requests: m1 first, m0 right after m1's last beat
    doReset();
    tick();
    m0_cmd_en = 1'b1; m0_addr = 4'd9;
    m1_cmd_en = 1'b1; m1_cmd = 1'b0; m1_addr = 4'd2;
    sample();
    checkOutput("sim_m0_busy", m0_busy, 1);
    checkOutput("sim_m1_busy", m1_busy, 0);
    tick();
    m1_cmd_en = 1'b0;
    sample();
    checkOutput("sim_m1_grant", m1_grant, 1);
    checkOutput("sim_m0_grant", m0_grant, 0);
    checkOutput("sim_br_addr", br_addr, 2);
    for (int k = 0; k < NB; k++) begin
      tick();
      br_rd_data_valid = 1'b1;
      sample();
      checkOutput("sim_m1_valid", m1_rd_data_valid, 1);
      checkOutput("sim_m0_valid", m0_rd_data_valid, 0);
    end
    tick();
    br_rd_data_valid = 1'b0;
    sample();
    checkOutput("sim_m0_busy_after", m0_busy, 0);
    tick();
    m0_cmd_en = 1'b0;
    sample();
    checkOutput("sim_m0_grant_after", m0_grant, 1);
    checkOutput("sim_br_addr_m0", br_addr, 9);

    // Reset after the second read beat
    doReset();
    tick();
    m0_cmd_en = 1'b1; m0_addr = 4'd3;
    tick();
    m0_cmd_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      br_rd_data_valid = 1'b1;
      sample();
      checkOutput("mid_m0_valid", m0_rd_data_valid, 1);
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sample();
    checkOutput("mid_rst_m0_valid", m0_rd_data_valid, 0);
    checkOutput("mid_rst_m1_valid", m1_rd_data_valid, 0);
    checkOutput("mid_rst_br_cmd_en", br_cmd_en, 0);
    checkOutput("mid_rst_br_addr", br_addr, 0);
    checkOutput("mid_rst_m0_busy", m0_busy, 0);
    tick();
    m1_cmd_en = 1'b1; m1_cmd = 1'b0; m1_addr = 4'd6;
    sample();
    checkOutput("mid_stray_m0_valid", m0_rd_data_valid, 0);
    checkOutput("mid_m1_busy", m1_busy, 0);
    tick();
    m1_cmd_en = 1'b0;
    br_rd_data_valid = 1'b0;
    sample();
    checkOutput("mid_m1_grant", m1_grant, 1);
    checkOutput("mid_br_addr", br_addr, 6);
    for (int k = 0; k < NB; k++) begin
      tick();
      br_rd_data_valid = 1'b1;
      sample();
      checkOutput("mid_m1_valid", m1_rd_data_valid, 1);
      checkOutput("mid_m0_valid_off", m0_rd_data_valid, 0);
    end
    tick();
    sample();
    checkOutput("mid_m1_done_valid", m1_rd_data_valid, 0);

`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
    // Both ports requesting continuously alternate, m1 first
    doReset();
    tick();
    m0_cmd_en = 1'b1; m0_addr = 4'd1;
    m1_cmd_en = 1'b1; m1_cmd = 1'b0; m1_addr = 4'd2;
    br_rd_data_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      sample();
      if (m0_grant) order.push_back(0);
      if (m1_grant) order.push_back(1);
      tick();
    end
    checkOutput("rr_grant_count_ge4", (order.size() >= 4), 1);
    if (order.size() >= 4) begin
      checkOutput("rr_grant0", order[0], 1);
      checkOutput("rr_grant1", order[1], 0);
      checkOutput("rr_grant2", order[2], 1);
      checkOutput("rr_grant3", order[3], 0);
    end
`endif

    // Randomized traffic against the reference model
    doReset();
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n            = ($urandom_range(0, 299) != 0);
      m0_cmd_en        = ($urandom_range(0, 2) != 0);
      m0_addr          = AW'($urandom);
      m1_cmd_en        = ($urandom_range(0, 2) != 0);
      m1_cmd           = $urandom_range(0, 1);
      m1_addr          = AW'($urandom);
      m1_wr_data       = {$urandom, $urandom};
      m1_data_mask     = MW'($urandom);
      br_busy          = ($urandom_range(0, 5) == 0);
      br_rd_data_valid = $urandom_range(0, 1);
      br_rd_data       = {$urandom, $urandom};
      sample();

      free = (mdl_left == 0);
`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
      pick1 = m1_cmd_en && (!m0_cmd_en || !mdl_last1);
`else
      pick1 = m1_cmd_en;
`endif
      win = free && !br_busy && (m0_cmd_en || m1_cmd_en);

      checkOutput("rnd_m0_busy", m0_busy, !free || br_busy || (win && pick1));
      checkOutput("rnd_m1_busy", m1_busy, !free || br_busy || (win && !pick1));
      checkOutput("rnd_m0_valid", m0_rd_data_valid, !free && !mdl_write && !mdl_owner1 && br_rd_data_valid);
      checkOutput("rnd_m1_valid", m1_rd_data_valid, !free && !mdl_write && mdl_owner1 && br_rd_data_valid);
      checkOutput("rnd_m1_rd_data", m1_rd_data, br_rd_data);
      checkOutput("rnd_m0_grant", m0_grant, mdl_g0);
      checkOutput("rnd_m1_grant", m1_grant, mdl_g1);
      checkOutput("rnd_br_cmd_en", br_cmd_en, mdl_cen);
      checkOutput("rnd_br_addr", br_addr, mdl_addr);
      checkOutput("rnd_br_cmd", br_cmd, mdl_cmd);
      if (mdl_chk_w) begin
        checkOutput("rnd_br_wr_data", br_wr_data, mdl_wd);
        checkOutput("rnd_br_data_mask", br_data_mask, mdl_mask);
      end

      if (!rst_n) begin
        modelReset();
      end else begin
        mdl_g0    = 1'b0;
        mdl_g1    = 1'b0;
        mdl_cen   = 1'b0;
        mdl_chk_w = 1'b0;
        if (win) begin
          mdl_cen    = 1'b1;
          mdl_owner1 = pick1;
          mdl_last1  = pick1;
          if (pick1) begin
            mdl_g1    = 1'b1;
            mdl_cmd   = m1_cmd;
            mdl_addr  = m1_addr;
            mdl_write = m1_cmd;
            mdl_wd    = m1_wr_data;
            mdl_mask  = m1_data_mask;
            mdl_chk_w = m1_cmd;
          end else begin
            mdl_g0    = 1'b1;
            mdl_cmd   = 1'b0;
            mdl_addr  = m0_addr;
            mdl_write = 1'b0;
          end
          mdl_left = mdl_write ? NB - 1 : NB;
        end else if (!free) begin
          if (mdl_write) begin
            mdl_wd    = m1_wr_data;
            mdl_mask  = m1_data_mask;
            mdl_chk_w = 1'b1;
            mdl_left--;
          end else if (br_rd_data_valid) begin
            mdl_left--;
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
